// File: rtl/bpred_pkg.sv
// Shared types and helpers for the fetch-side branch predictor.
//   OPC_BRANCH / OPC_JAL : opcodes that train the table
//   ctr_t                : 2-bit saturating direction counter
//   bpred_entry_t        : one table entry (valid, tag, ctr, target)
//   sat_next()           : counter next-state for a resolved outcome
package bpred_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Widest possible tag (INDEX_BITS=0). Narrower configurations store the
  // tag zero-extended, so the unused upper flops are constant and trimmed.
  localparam int TAG_W_MAX = 30;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    ctr_t                 ctr;
    logic [31:0]          target;
  } bpred_entry_t;

  function automatic ctr_t sat_next(ctr_t c, logic taken);
    if (taken) return (c == ST)  ? ST  : ctr_t'(c + 2'd1);
    else       return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bpred_sat_counter.sv
// Combinational next state of one 2-bit saturating direction counter.
//   ctr_i   : current counter value
//   taken_i : resolved direction
//   ctr_o   : counter after training with taken_i
module bpred_sat_counter
  import bpred_pkg::*;
(
  input  ctr_t ctr_i,
  input  logic taken_i,
  output ctr_t ctr_o
);

  assign ctr_o = sat_next(ctr_i, taken_i);

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counter branch predictor.
// Lookup of fetch_pc is combinational; training from resolved branches/JALs
// lands on the rising edge and is visible the following cycle (no bypass).
//   clk, rst             : clock, synchronous active-high reset
//   fetch_pc             : PC being fetched
//   pred_taken/target    : redirect prediction for fetch_pc
//   upd_*                : resolved instruction used to train the table
// Optional macro BPRED_STATS_EN adds stat_branches / stat_mispredicts,
// saturating counters of trained control-flow ops and direction mispredicts.
module branch_predictor
  import bpred_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 32 - INDEX_BITS - 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [6:0]  upd_opcode,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int NUM_ENTRIES = 1 << INDEX_BITS;

  bpred_entry_t tbl_q [NUM_ENTRIES];

  // ---------------- lookup ----------------
  logic [INDEX_BITS-1:0] f_idx;
  logic [TAG_W_MAX-1:0]  f_tag;
  bpred_entry_t          f_ent;
  logic                  f_hit;

  assign f_idx = fetch_pc[INDEX_BITS+1:2];
  assign f_tag = TAG_W_MAX'(fetch_pc[31:32-TAG_BITS]);

  always_comb begin
    f_ent       = tbl_q[f_idx];
    f_hit       = f_ent.valid && (f_ent.tag == f_tag);
    // rst gates the prediction so uninitialised entries never redirect fetch
    pred_taken  = !rst && f_hit && (f_ent.ctr inside {WT, ST});
    pred_target = pred_taken ? f_ent.target : fetch_pc + 32'd4;
  end

  // ---------------- training ----------------
  logic [INDEX_BITS-1:0] u_idx;
  logic [TAG_W_MAX-1:0]  u_tag;
  bpred_entry_t          u_ent;
  logic                  u_hit;
  ctr_t                  u_ctr_nxt;
  logic                  wr_en;
  bpred_entry_t          wr_ent;

  assign u_idx = upd_pc[INDEX_BITS+1:2];
  assign u_tag = TAG_W_MAX'(upd_pc[31:32-TAG_BITS]);
  assign u_ent = tbl_q[u_idx];
  assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

  bpred_sat_counter u_sat (
    .ctr_i   (u_ent.ctr),
    .taken_i (upd_taken),
    .ctr_o   (u_ctr_nxt)
  );

  always_comb begin
    wr_en  = 1'b0;
    wr_ent = u_ent;
    if (upd_valid) begin
      if (upd_opcode == OPC_JAL) begin
        wr_en         = 1'b1;
        wr_ent.valid  = 1'b1;
        wr_ent.tag    = u_tag;
        wr_ent.ctr    = ST;
        wr_ent.target = upd_target;
      end else if (upd_opcode == OPC_BRANCH) begin
        wr_en = 1'b1;
        if (u_hit) begin
          wr_ent.ctr = u_ctr_nxt;
          // a not-taken outcome says nothing about where the branch goes
          if (upd_taken) wr_ent.target = upd_target;
        end else begin
          wr_ent.valid  = 1'b1;
          wr_ent.tag    = u_tag;
          wr_ent.ctr    = upd_taken ? WT : WNT;
          wr_ent.target = upd_target;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tbl_q[i].valid <= 1'b0;
        tbl_q[i].ctr   <= WNT;
      end
    end else if (wr_en) begin
      tbl_q[u_idx] <= wr_ent;
    end
  end

`ifdef BPRED_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;
  logic        is_cf;

  assign is_cf = upd_valid && (upd_opcode == OPC_BRANCH || upd_opcode == OPC_JAL);

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (is_cf) begin
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 32'd1;
      if (upd_pred_taken != upd_taken && mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign stat_branches    = br_cnt_q;
  assign stat_mispredicts = mp_cnt_q;
`endif

  // pc[1:0] never participates in indexing or tagging
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0], upd_pred_taken};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a
// randomized run compared against a table model kept as plain int arrays.
module tb_branch_predictor;
  localparam int IB = 6;
  localparam int NE = 1 << IB;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] ALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [6:0]  upd_opcode;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
`ifdef BPRED_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int vectors = 0;
  int miscompares = 0;

  branch_predictor dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_opcode(upd_opcode),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken)
`ifdef BPRED_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_valid [NE];
  int unsigned m_tag   [NE];
  int          m_ctr   [NE];   // 0..3, predicts taken when >= 2
  logic [31:0] m_tgt   [NE];
  longint      m_br, m_mp;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % NE);
  endfunction

  function automatic int unsigned mtag(input logic [31:0] pc);
    return pc >> (IB + 2);
  endfunction

  function automatic logic m_taken(input logic [31:0] pc);
    int i = midx(pc);
    if (rst) return 1'b0;
    return (m_valid[i] != 0 && m_tag[i] == mtag(pc) && m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[midx(pc)] : pc + 32'd4;
  endfunction

  function automatic void m_apply();
    int i;
    if (rst) begin
      for (int k = 0; k < NE; k++) begin m_valid[k] = 0; m_ctr[k] = 1; end
      m_br = 0; m_mp = 0;
      return;
    end
    if (!upd_valid) return;
    i = midx(upd_pc);
    if (upd_opcode == JAL) begin
      m_valid[i] = 1; m_tag[i] = mtag(upd_pc); m_ctr[i] = 3; m_tgt[i] = upd_target;
    end else if (upd_opcode == BR) begin
      if (m_valid[i] != 0 && m_tag[i] == mtag(upd_pc)) begin
        if (upd_taken) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = upd_target;
        end else m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end else begin
        m_valid[i] = 1; m_tag[i] = mtag(upd_pc);
        m_ctr[i] = upd_taken ? 2 : 1; m_tgt[i] = upd_target;
      end
    end
    if (upd_opcode == JAL || upd_opcode == BR) begin
      if (m_br < 64'hFFFF_FFFF) m_br++;
      if (upd_pred_taken != upd_taken && m_mp < 64'hFFFF_FFFF) m_mp++;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                       input logic [6:0] opc, input logic tk, input logic [31:0] tgt,
                       input logic ptk);
    fetch_pc = fpc; upd_valid = uv; upd_pc = upc; upd_opcode = opc;
    upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    m_apply();
    #1;
  endtask

  // fetch-only cycle (no update)
  task automatic look(input logic [31:0] fpc);
    drive(fpc, 1'b0, 32'h0, ALU, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input logic [6:0] opc, input logic tk,
                       input logic [31:0] tgt);
    drive(pc, 1'b1, pc, opc, tk, tgt, 1'b0);
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(32'h100, 1'b1, 32'h100, BR, 1'b1, 32'h80, 1'b0);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      miscompares++; $display("FAIL reset_pre: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
    tick();
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      miscompares++; $display("FAIL reset_held: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
    rst = 1'b0;
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      miscompares++; $display("FAIL reset_upd_dropped: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
    look(32'hFFFF_FFFC);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      miscompares++; $display("FAIL wrap_plus4: got %b/%h want 0/00000000", pred_taken, pred_target);
    end
  endtask

  task automatic test_train();
    train(32'h100, BR, 1'b1, 32'h80);
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      miscompares++; $display("FAIL train_taken: got %b/%h want 1/00000080", pred_taken, pred_target);
    end
    look(32'h102);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      miscompares++; $display("FAIL pc_lsbs_ignored: got %b/%h want 1/00000080", pred_taken, pred_target);
    end
    train(32'h100, BR, 1'b0, 32'h1234);
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      miscompares++; $display("FAIL train_not_taken: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
  endtask

  task automatic test_saturation();
    // from WNT: 4 taken -> ST, last one moves target to 0x90
    train(32'h100, BR, 1'b1, 32'h80);
    train(32'h100, BR, 1'b1, 32'h80);
    train(32'h100, BR, 1'b1, 32'h80);
    train(32'h100, BR, 1'b1, 32'h90);
    train(32'h100, BR, 1'b0, 32'h1234);
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h90) begin
      miscompares++; $display("FAIL sat_st_to_wt: got %b/%h want 1/00000090", pred_taken, pred_target);
    end
    train(32'h100, BR, 1'b0, 32'h0);
    train(32'h100, BR, 1'b0, 32'h0);
    train(32'h100, BR, 1'b0, 32'h0);
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      miscompares++; $display("FAIL sat_snt: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
    train(32'h100, BR, 1'b0, 32'h0);
    // one taken from SNT only reaches WNT: still not-taken
    train(32'h100, BR, 1'b1, 32'hA0);
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      miscompares++; $display("FAIL sat_snt_floor: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
  endtask

  task automatic test_jal_alias();
    logic [31:0] alias_pc;
    alias_pc = 32'h200 + (32'd4 << IB);
    train(32'h200, JAL, 1'b1, 32'h400);
    look(32'h200);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h400) begin
      miscompares++; $display("FAIL jal_hit: got %b/%h want 1/00000400", pred_taken, pred_target);
    end
    look(alias_pc);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== alias_pc + 32'd4) begin
      miscompares++; $display("FAIL alias_miss: got %b/%h want 0/%h", pred_taken, pred_target, alias_pc + 32'd4);
    end
    train(alias_pc, BR, 1'b1, 32'h500);
    look(alias_pc);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h500) begin
      miscompares++; $display("FAIL alias_alloc: got %b/%h want 1/00000500", pred_taken, pred_target);
    end
    look(32'h200);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin
      miscompares++; $display("FAIL jal_evicted: got %b/%h want 0/00000204", pred_taken, pred_target);
    end
    // not-taken miss allocates at WNT: a single taken then predicts taken
    train(32'h700, BR, 1'b0, 32'h600);
    look(32'h700);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h704) begin
      miscompares++; $display("FAIL alloc_nt: got %b/%h want 0/00000704", pred_taken, pred_target);
    end
    train(32'h700, BR, 1'b1, 32'h600);
    look(32'h700);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h600) begin
      miscompares++; $display("FAIL alloc_nt_is_wnt: got %b/%h want 1/00000600", pred_taken, pred_target);
    end
  endtask

  task automatic test_same_cycle();
    // 0x100 is at WNT here
    drive(32'h100, 1'b1, 32'h100, BR, 1'b1, 32'hA0, 1'b0);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      miscompares++; $display("FAIL same_cycle_old: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
    tick();
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'hA0) begin
      miscompares++; $display("FAIL same_cycle_new: got %b/%h want 1/000000a0", pred_taken, pred_target);
    end
    train(32'h100, ALU, 1'b0, 32'hFFF0);
    drive(32'h100, 1'b0, 32'h100, BR, 1'b0, 32'hFFF0, 1'b0);
    tick();
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 32'hA0) begin
      miscompares++; $display("FAIL no_update_ops: got %b/%h want 1/000000a0", pred_taken, pred_target);
    end
  endtask

  task automatic test_mid_reset();
    train(32'h200, JAL, 1'b1, 32'h400);
    rst = 1'b1; look(32'h0); tick(); rst = 1'b0;
    look(32'h100);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      miscompares++; $display("FAIL mid_reset_100: got %b/%h want 0/00000104", pred_taken, pred_target);
    end
    look(32'h200);
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin
      miscompares++; $display("FAIL mid_reset_200: got %b/%h want 0/00000204", pred_taken, pred_target);
    end
  endtask

`ifdef BPRED_STATS_EN
  task automatic test_stats();
    rst = 1'b1; look(32'h0); tick(); rst = 1'b0;
    drive(32'h0, 1'b1, 32'h100, BR,  1'b1, 32'h80,  1'b1); tick();
    drive(32'h0, 1'b1, 32'h200, JAL, 1'b1, 32'h400, 1'b0); tick();
    drive(32'h0, 1'b1, 32'h300, BR,  1'b0, 32'h0,   1'b0); tick();
    drive(32'h0, 1'b1, 32'h300, ALU, 1'b1, 32'h0,   1'b0); tick();
    vectors++;
    if (stat_branches !== 32'd3 || stat_mispredicts !== 32'd1) begin
      miscompares++; $display("FAIL stats_count: got %0d/%0d want 3/1", stat_branches, stat_mispredicts);
    end
    rst = 1'b1; look(32'h0); tick(); rst = 1'b0;
    vectors++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      miscompares++; $display("FAIL stats_reset: got %0d/%0d want 0/0", stat_branches, stat_mispredicts);
    end
  endtask
`endif

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << (IB + 2)) | (32'($urandom_range(0, 7)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    logic [6:0] opc;
    logic       exp_t;
    logic [31:0] exp_g;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: opc = JAL;
        1: opc = ALU;
        default: opc = BR;
      endcase
      rst = ($urandom_range(0, 59) == 0);
      drive(rnd_pc(), 1'($urandom_range(0, 3) != 0), rnd_pc(), opc,
            1'($urandom), $urandom, 1'($urandom));
      exp_t = m_taken(fetch_pc);
      exp_g = m_target(fetch_pc);
      vectors++;
      if (pred_taken !== exp_t || pred_target !== exp_g) begin
        miscompares++;
        $display("FAIL random_lookup[%0d] pc=%h: got %b/%h want %b/%h",
                 n, fetch_pc, pred_taken, pred_target, exp_t, exp_g);
      end
      tick();
`ifdef BPRED_STATS_EN
      vectors++;
      if (stat_branches !== 32'(m_br) || stat_mispredicts !== 32'(m_mp)) begin
        miscompares++;
        $display("FAIL random_stats[%0d]: got %0d/%0d want %0d/%0d",
                 n, stat_branches, stat_mispredicts, m_br, m_mp);
      end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NE; k++) begin
      m_valid[k] = 0; m_tag[k] = 0; m_ctr[k] = 1; m_tgt[k] = '0;
    end
    m_br = 0; m_mp = 0;
    rst = 1'b1;
    look(32'h0);
    test_reset();
    test_train();
    test_saturation();
    test_jal_alias();
    test_same_cycle();
    test_mid_reset();
`ifdef BPRED_STATS_EN
    test_stats();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart to branch resolution in the RISC-V core.
- Predicts taken/target for the current fetch PC from a direct-mapped table. Each entry holds a BTB target plus a 2-bit saturating counter.
- The table is trained from the resolved outcome (br_taken, target) of each executed branch or JAL.
- Sits beside the PC register. The PC mux uses pred_taken/pred_target to pick the next fetch address.

Parameters:
- INDEX_BITS, 6, table index width; the table has 2^INDEX_BITS entries.
- TAG_BITS, 32-INDEX_BITS-2, tag width; equals pc[31:INDEX_BITS+2].

Ports:
- clk  input  1  core clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- fetch_pc  input  32  PC being fetched this cycle.
- pred_taken  output  1  predict redirect for fetch_pc.
- pred_target  output  32  predicted next PC.
- upd_valid  input  1  resolved instruction present this cycle.
- upd_pc  input  32  PC of the resolved instruction.
- upd_opcode  input  7  opcode of the resolved instruction.
- upd_taken  input  1  resolved br_taken.
- upd_target  input  32  resolved branch/jump target.
- upd_pred_taken  input  1  prediction originally made for upd_pc (used by the optional stats).

Behaviour:
- Clock and reset are fixed: one clock; reset is synchronous and active-high (clk, rst).
- Index is pc[INDEX_BITS+1:2]; tag is pc[31:INDEX_BITS+2]; pc[1:0] is ignored.
- Entry contents: valid, tag, ctr[1:0], target[31:0].
- Counter states: SNT=00, WNT=01, WT=10, ST=11.
- Lookup is combinational, with zero latency:
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_target = pred_taken ? target : fetch_pc+4, with 32-bit wrap (0xFFFFFFFC+4 = 0x00000000).
- Updates apply at the rising edge when upd_valid=1 and rst=0:
  - JAL (1101111): write the entry with valid=1, new tag, ctr=ST, target=upd_target.
  - BRANCH (1100011), hit: the counter saturates.
    - taken: SNT→WNT→WT→ST→ST.
    - not-taken: ST→WT→WNT→SNT→SNT.
    - target is rewritten with upd_target only when upd_taken=1.
  - BRANCH (1100011), miss: allocate, overwriting any other tag.
    - valid=1, new tag, target=upd_target.
    - ctr = upd_taken ? WT : WNT.
  - Any other opcode, or upd_valid=0: no table change.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. There is no write bypass; the new value is visible the next cycle.
- Reset:
  - At a rising edge with rst=1, all valid bits clear and all ctr go to WNT; target/tag contents are don't-care.
  - While rst=1, pred_taken=0 and pred_target=fetch_pc+4.
  - An update presented in the same cycle as rst is dropped.
  - Reset asserted mid-training discards all learned state.

Optional Feature:
- Macro BPRED_STATS_EN.
- Defined: adds output ports stat_branches[31:0] and stat_mispredicts[31:0], both reset to 0.
  - On each update with upd_valid and opcode BRANCH or JAL, stat_branches increments.
  - If upd_pred_taken != upd_taken, stat_mispredicts also increments.
  - Both counters saturate at 0xFFFFFFFF.
- Undefined: the ports and logic are absent; the predictor's behaviour is unchanged.

Decomposition:
- Package bpred_pkg holds:
  - Opcode constants OPC_BRANCH=7'b1100011 and OPC_JAL=7'b1101111.
  - Counter enum ctr_t {SNT, WNT, WT, ST}.
  - Entry struct bpred_entry_t {valid, tag, ctr, target}.
  - A sat_next(ctr_t, taken) function.
- One sub-module, bpred_sat_counter: combinational next-state for one 2-bit counter, instanced once on the update path.
- Table storage is a flop array inside branch_predictor.

Test Plan:
- Reset, then fetch_pc=0x100 → pred_taken=0, pred_target=0x104. Repeat with rst held high → same outputs.
- Update BRANCH pc=0x100 taken, target=0x80 → next cycle, fetch 0x100 gives pred_taken=1, pred_target=0x80 (ctr=WT). One not-taken update → WNT, pred_taken=0, pred_target=0x104.
- Saturation on pc=0x100: 4 taken updates → ST; 1 not-taken → WT, still predicts taken. 3 further not-taken → SNT; a 4th stays SNT.
- JAL at pc=0x200, target=0x400 → pred_taken=1, pred_target=0x400. An aliasing pc 0x200+(4<<INDEX_BITS) (0x300 with the default) misses until it allocates, then evicts the JAL entry.
- Same-cycle lookup and update of pc=0x100: fetch sees the old prediction that cycle and the new one the following cycle. An upd_opcode=0110011 update leaves the table unchanged.
- With BPRED_STATS_EN defined, 3 updates of which 1 mismatches upd_pred_taken → stat_branches=3, stat_mispredicts=1. rst returns both to 0.
